// File: rtl/rule110_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : rule110_pkg                                              |
// | Brief   : Shared state encoding and phase-select helper for the    |
// |           rule110 array sequencer.                                 |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package rule110_pkg;

  localparam int CELLS_PER_BLOCK = 8;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD       = 3'd1,
    S_RUN        = 3'd2,
    S_DUMP_ISSUE = 3'd3,
    S_DUMP_HOLD  = 3'd4,
    S_DONE       = 3'd5
  } state_t;

  // Phase that follows once any LOAD is finished (zero generations skip RUN).
  function automatic state_t next_phase(input logic gens_zero, input logic dump);
    state_t v_st;
    if (!gens_zero)
      v_st = S_RUN;
    else if (dump)
      v_st = S_DUMP_ISSUE;
    else
      v_st = S_DONE;
    return v_st;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rule110_block_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : rule110_block_counter                                    |
// | Brief   : Block index 0..NUM_BLOCKS-1 with clear, increment and    |
// |           last-block flag; wraps to 0 after the last block.        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module rule110_block_counter #(
  parameter int NUM_BLOCKS = 28,
  parameter int ADDR_BITS  = $clog2(NUM_BLOCKS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clr,
  input  logic                 i_inc,
  output logic [ADDR_BITS-1:0] o_blk,
  output logic                 o_last
);

  localparam logic [ADDR_BITS-1:0] c_LAST_BLK = ADDR_BITS'(NUM_BLOCKS - 1);

  logic [ADDR_BITS-1:0] r_blk;

  always_ff @(posedge clk) begin
    if (reset || i_clr)
      r_blk <= '0;
    else if (i_inc)
      r_blk <= (r_blk == c_LAST_BLK) ? '0 : r_blk + 1'b1;
  end

  assign o_blk  = r_blk;
  assign o_last = (r_blk == c_LAST_BLK);

endmodule
`default_nettype wire

// File: rtl/rule110_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : rule110_sequencer                                        |
// | Brief   : LOAD / RUN / DUMP command sequencer driving the rule110  |
// |           cell array pins from a byte-stream host port.            |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module rule110_sequencer
  import rule110_pkg::*;
#(
  parameter int NUM_BLOCKS = 28,
  parameter int ADDR_BITS  = $clog2(NUM_BLOCKS),
  parameter int GEN_BITS   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_load,
  input  logic                       cmd_dump,
  input  logic [GEN_BITS-1:0]        cmd_gens,
  input  logic                       ld_valid,
  input  logic [CELLS_PER_BLOCK-1:0] ld_data,
  output logic                       ld_ready,
  output logic                       dp_valid,
  output logic [CELLS_PER_BLOCK-1:0] dp_data,
  input  logic                       dp_ready,
  output logic                       done,
  output logic [CELLS_PER_BLOCK-1:0] ca_data_in,
  input  logic [CELLS_PER_BLOCK-1:0] ca_data_out,
  output logic                       ca_we_n,
  output logic                       ca_halt_n,
  output logic [ADDR_BITS-1:0]       ca_addr
);

  state_t                       r_state;
  state_t                       w_next;
  logic [GEN_BITS-1:0]          r_gen;
  logic                         r_dump;
  logic [CELLS_PER_BLOCK-1:0]   r_dp_data;
  logic                         w_live;
  logic                         w_accept;
  logic                         w_ld_hs;
  logic                         w_dp_hs;
  logic [ADDR_BITS-1:0]         w_blk;
  logic                         w_last;

  // Pin outputs are gated by reset so an abort freezes the array at once.
  assign w_live     = !reset;
  assign cmd_ready  = w_live && (r_state == S_IDLE);
  assign w_accept   = cmd_valid && cmd_ready;
  assign ld_ready   = w_live && (r_state == S_LOAD);
  assign w_ld_hs    = ld_ready && ld_valid;
  assign dp_valid   = w_live && (r_state == S_DUMP_HOLD);
  assign w_dp_hs    = dp_valid && dp_ready;
  assign dp_data    = r_dp_data;
  assign done       = w_live && (r_state == S_DONE);
  assign ca_we_n    = !w_ld_hs;
  assign ca_halt_n  = w_live && (r_state == S_RUN);
  assign ca_data_in = ld_ready ? ld_data : '0;
  assign ca_addr    = (ld_ready || dp_valid || (w_live && r_state == S_DUMP_ISSUE)) ? w_blk : '0;

  rule110_block_counter #(
    .NUM_BLOCKS (NUM_BLOCKS),
    .ADDR_BITS  (ADDR_BITS)
  ) u_blk_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_accept),
    .i_inc  (w_ld_hs || w_dp_hs),
    .o_blk  (w_blk),
    .o_last (w_last)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (w_accept)
                      w_next = cmd_load ? S_LOAD : next_phase(cmd_gens == '0, cmd_dump);
      S_LOAD:       if (w_ld_hs && w_last)
                      w_next = next_phase(r_gen == '0, r_dump);
      S_RUN:        if (r_gen <= GEN_BITS'(1))
                      w_next = r_dump ? S_DUMP_ISSUE : S_DONE;
      S_DUMP_ISSUE: w_next = S_DUMP_HOLD;
      S_DUMP_HOLD:  if (w_dp_hs)
                      w_next = w_last ? S_DONE : S_DUMP_ISSUE;
      S_DONE:       w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_gen     <= '0;
      r_dump    <= 1'b0;
      r_dp_data <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_gen  <= cmd_gens;
        r_dump <= cmd_dump;
      end else if (r_state == S_RUN) begin
        r_gen <= r_gen - 1'b1;
      end
      // ca_data_out is already the next-generation view of the addressed block.
      if (r_state == S_DUMP_ISSUE)
        r_dp_data <= ca_data_out;
    end
  end

endmodule
`default_nettype wire
